fetch_unit: RTL

Instruction fetch front end that supplies the decode/controller stage with instructions and their PCs, and accepts the controller's taken-branch/jump redirect (PCSrc plus target) as its control input. It owns the fetch PC, issues in-order read requests to instruction memory over a valid/ready request channel with a valid-only response channel, buffers returned words in a small FIFO, and flushes stale work on redirect. It sits between instruction memory and the controller/datapath, replacing the combinational PC-plus-ROM path.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end; issues in-order imem reads, buffers {pc, word} and flushes on redirect.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misalign_err and halts issue after an unaligned redirect target.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] trk_wr_q, trk_wr_d;
    logic [AW-1:0] trk_rd_q, trk_rd_d;

    logic [31:0] fifo_pc_q   [DEPTH];
    logic [31:0] fifo_word_q [DEPTH];
    logic [31:0] trk_pc_q    [DEPTH];

    logic        halt;
    logic [31:0] redirect_pc;
    logic        req_fire;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic [CW:0] inflight;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halt_q, halt_d;
    assign halt         = halt_q;
    assign misalign_err = halt_q;
    assign redirect_pc  = redirect_target;
`else
    assign halt         = 1'b0;
    assign redirect_pc  = redirect_target & 32'hFFFF_FFFC;
`endif

    // Issue gating reserves a FIFO slot for every request that may still return, dropped ones included.
    assign inflight       = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
    assign imem_req_valid = ~reset & ~halt & (inflight < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
    assign push     = imem_rsp_valid & ~rsp_drop & ~redirect_valid;
    assign pop      = instr_valid & instr_ready;

    assign instr_valid   = (fifo_cnt_q != '0);
    assign instr         = fifo_word_q[rd_ptr_q];
    assign instr_pc      = fifo_pc_q[rd_ptr_q];
    assign instr_pcplus4 = instr_pc + 32'd4;

    always_comb begin
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
        trk_wr_d   = trk_wr_q + AW'(req_fire);
        trk_rd_d   = trk_rd_q + AW'(imem_rsp_valid);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
`ifdef FETCH_MISALIGN_CHECK_EN
        halt_d     = halt_q;
`endif
        // After a redirect every request still outstanding belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_cnt_d = out_cnt_d;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_d     = (redirect_target[1:0] != 2'b00);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            trk_wr_q   <= '0;
            trk_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            trk_wr_q   <= trk_wr_d;
            trk_rd_q   <= trk_rd_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    // Issued-PC tracker pops on every response, so dropped responses keep it aligned with memory order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= 32'h0;
                fifo_word_q[i] <= 32'h0;
                trk_pc_q[i]    <= 32'h0;
            end
        end else begin
            if (req_fire) begin
                trk_pc_q[trk_wr_q] <= fetch_pc_q;
            end
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= trk_pc_q[trk_rd_q];
                fifo_word_q[wr_ptr_q] <= imem_rsp_data;
            end
        end
    end

endmodule
